// File: rtl/shreg_serial_scheduler.sv
// Round-robin scheduler that shares one parallel-load shift register among NREQ
// requesters, serialising each accepted word MSB-first with an optional idle gap.
module shreg_serial_scheduler #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned GAP   = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   data,
  input  logic                    en,
  output logic [NREQ-1:0]         ack,
  output logic [NREQ-1:0]         grant,
  output logic                    so,
  output logic                    so_valid,
  output logic                    so_first,
  output logic                    so_last,
  output logic                    busy
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW   = $clog2(WIDTH);
  localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);
  localparam logic [7:0]      GAP_M1   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t            state;
  logic [WIDTH-1:0]  shreg;
  logic [BW-1:0]     bitcnt;
  logic [7:0]        gapcnt;
  logic [IDXW-1:0]   last_winner;
  logic [IDXW-1:0]   winner;
  logic [IDXW-1:0]   idx;
  logic              found;

  // Search starts just after the previous winner and wraps modulo NREQ.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDXW'((32'(last_winner) + i) % NREQ);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      shreg       <= '0;
      bitcnt      <= '0;
      gapcnt      <= '0;
      last_winner <= IDXW'(NREQ - 1);
      ack         <= '0;
      grant       <= '0;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (found) begin
            shreg       <= data[32'(winner)*WIDTH +: WIDTH];
            grant       <= NREQ'(1) << winner;
            ack         <= NREQ'(1) << winner;
            last_winner <= winner;
            bitcnt      <= '0;
            state       <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (en) begin
            shreg <= {shreg[WIDTH-2:0], 1'b0};
            if (bitcnt == LAST_BIT) begin
              bitcnt <= '0;
              grant  <= '0;
              if (GAP > 0) begin
                gapcnt <= GAP_M1;
                state  <= S_GAP;
              end else begin
                state  <= S_IDLE;
              end
            end else begin
              bitcnt <= bitcnt + 1'b1;
            end
          end
        end
        S_GAP: begin
          if (en) begin
            if (gapcnt == '0) state <= S_IDLE;
            else              gapcnt <= gapcnt - 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // The frame is fully shifted out by the time GAP/IDLE is entered, so so reads 0 there.
  assign so       = shreg[WIDTH-1];
  assign busy     = (state != S_IDLE);
  assign so_valid = (state == S_SHIFT) && en;
  assign so_first = so_valid && (bitcnt == '0);
  assign so_last  = so_valid && (bitcnt == LAST_BIT);

endmodule

// File: tb/tb_shreg_serial_scheduler.sv
// Directed bench for shreg_serial_scheduler: one GAP=0 and one GAP=3 instance share
// stimulus; the one under test is selected onto the observation signals.
module tb_shreg_serial_scheduler;

  logic         clk;
  logic         rst0, rst3;
  logic [3:0]   req;
  logic [127:0] data;
  logic         en;
  logic         sel;

  logic [3:0] ack0, grant0, ack3, grant3;
  logic       so0, sv0, sf0, sl0, busy0;
  logic       so3, sv3, sf3, sl3, busy3;

  logic [3:0] o_ack, o_grant;
  logic       o_so, o_so_valid, o_so_first, o_so_last, o_busy;

  int n_chk;
  int n_fail;
  int cyc;
  int mark;

  shreg_serial_scheduler #(.WIDTH(32), .NREQ(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst0), .req(req), .data(data), .en(en),
    .ack(ack0), .grant(grant0), .so(so0), .so_valid(sv0),
    .so_first(sf0), .so_last(sl0), .busy(busy0)
  );

  shreg_serial_scheduler #(.WIDTH(32), .NREQ(4), .GAP(3)) dut3 (
    .clk(clk), .rst(rst3), .req(req), .data(data), .en(en),
    .ack(ack3), .grant(grant3), .so(so3), .so_valid(sv3),
    .so_first(sf3), .so_last(sl3), .busy(busy3)
  );

  always_comb begin
    o_ack      = sel ? ack3   : ack0;
    o_grant    = sel ? grant3 : grant0;
    o_so       = sel ? so3    : so0;
    o_so_valid = sel ? sv3    : sv0;
    o_so_first = sel ? sf3    : sf0;
    o_so_last  = sel ? sl3    : sl0;
    o_busy     = sel ? busy3  : busy0;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Steps until an ack appears; returns at that negedge with delta from mark.
  task automatic wait_ack(input string tag, input logic [3:0] exp, output int delta);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (o_ack == 4'b0000 && n < 100);
    #1;
    if (o_ack == 4'b0000) chk({tag, "_timeout"}, 32'd0, 32'd1);
    chk({tag, "_ack"}, o_ack, exp);
    delta = cyc - mark;
    mark  = cyc;
  endtask

  // Entered at the negedge where bit 0 is presented; returns at the last checked bit.
  task automatic run_frame(input string tag, input logic [31:0] word, input logic [3:0] g,
                           input int nbits, input int stall_at, input int stall_len,
                           input int pulse_at, input logic [3:0] pulse_req);
    for (int b = 0; b < nbits; b++) begin
      if (b > 0) @(negedge clk);
      if (b == pulse_at) req = pulse_req;
      if (b == pulse_at + 1) req = 4'b0000;
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          en = 1'b0;
          #1;
          chk({tag, "_stall_valid"}, o_so_valid, 1'b0);
          chk({tag, "_stall_so"}, o_so, word[31-b]);
          chk({tag, "_stall_busy"}, o_busy, 1'b1);
          @(negedge clk);
        end
        en = 1'b1;
      end
      #1;
      chk({tag, "_so"}, o_so, word[31-b]);
      chk({tag, "_valid"}, o_so_valid, 1'b1);
      chk({tag, "_first"}, o_so_first, b == 0);
      chk({tag, "_last"}, o_so_last, b == 31);
      chk({tag, "_grant"}, o_grant, g);
      chk({tag, "_ackpulse"}, o_ack, (b == 0) ? g : 4'b0000);
      chk({tag, "_busy"}, o_busy, 1'b1);
    end
  endtask

  logic [31:0] words [4];
  int d;

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; mark = 0;
    sel = 1'b0; rst0 = 1'b1; rst3 = 1'b1;
    req = '0; data = '0; en = 1'b0;
    words[0] = 32'hDEAD_BEEF; words[1] = 32'h1234_5678;
    words[2] = 32'hCAFE_F00D; words[3] = 32'h0F0F_3C3C;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_ack", o_ack, 4'b0000);
    chk("rst_grant", o_grant, 4'b0000);
    chk("rst_so", o_so, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_valid", o_so_valid, 1'b0);

    // Single frame, GAP=0
    rst0 = 1'b0; req = 4'b0001; data[31:0] = 32'h8000_0001; en = 1'b1; mark = cyc;
    wait_ack("t1", 4'b0001, d);
    chk("t1_latency", d, 1);
    req = 4'b0000;
    run_frame("t1", 32'h8000_0001, 4'b0001, 32, -1, 0, -5, 4'b0000);
    @(negedge clk); #1;
    chk("t1_busy_fall", o_busy, 1'b0);
    chk("t1_grant_clr", o_grant, 4'b0000);

    // Round robin with all requests held
    rst0 = 1'b1; @(negedge clk); rst0 = 1'b0;
    data = {words[3], words[2], words[1], words[0]};
    req = 4'b1111; mark = cyc;
    for (int k = 0; k < 5; k++) begin
      wait_ack("t2", 4'b0001 << (k % 4), d);
      if (k > 0) chk("t2_spacing", d, 33);
      if (k == 4) req = 4'b0000;
      run_frame("t2", words[k % 4], 4'b0001 << (k % 4), 32, -1, 0, -5, 4'b0000);
    end
    @(negedge clk); #1;
    chk("t2_idle", o_busy, 1'b0);

    // Mid-frame enable stall at bit 10
    data[63:32] = 32'hA5A5_A5A5; req = 4'b0010; mark = cyc;
    wait_ack("t3", 4'b0010, d);
    req = 4'b0000;
    run_frame("t3", 32'hA5A5_A5A5, 4'b0010, 32, 10, 5, -5, 4'b0000);
    @(negedge clk); #1;
    chk("t3_done", o_busy, 1'b0);

    // GAP=3 instance
    rst0 = 1'b1; sel = 1'b1; rst3 = 1'b0;
    data[63:32] = 32'h3C00_00C3; req = 4'b0010; mark = cyc;
    wait_ack("t4", 4'b0010, d);
    run_frame("t4", 32'h3C00_00C3, 4'b0010, 32, -1, 0, -5, 4'b0000);
    for (int g = 0; g < 3; g++) begin
      @(negedge clk); #1;
      chk("t4_gap_so", o_so, 1'b0);
      chk("t4_gap_busy", o_busy, 1'b1);
      chk("t4_gap_grant", o_grant, 4'b0000);
      chk("t4_gap_valid", o_so_valid, 1'b0);
    end
    @(negedge clk); #1;
    chk("t4_idle_busy", o_busy, 1'b0);
    wait_ack("t4b", 4'b0010, d);
    chk("t4_spacing", d, 36);
    req = 4'b0000;

    // Reset mid-frame at bit 15 of requester 2
    rst3 = 1'b1; sel = 1'b0; rst0 = 1'b0;
    data = {words[3], words[2], words[1], words[0]};
    req = 4'b0100; mark = cyc;
    wait_ack("t5", 4'b0100, d);
    req = 4'b0000;
    run_frame("t5", words[2], 4'b0100, 16, -1, 0, -5, 4'b0000);
    rst0 = 1'b1;
    @(negedge clk); #1;
    chk("t5_ack", o_ack, 4'b0000);
    chk("t5_grant", o_grant, 4'b0000);
    chk("t5_busy", o_busy, 1'b0);
    chk("t5_so", o_so, 1'b0);
    chk("t5_valid", o_so_valid, 1'b0);
    rst0 = 1'b0; req = 4'b0101; mark = cyc;
    wait_ack("t5_after", 4'b0001, d);
    req = 4'b0000;

    // Request pulse during SHIFT is ignored
    run_frame("t6", words[0], 4'b0001, 32, -1, 0, 5, 4'b0010);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("t6_noack", o_ack, 4'b0000);
      chk("t6_idle", o_busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
